// File: rtl/duty_sched_if.sv
// Requester handshake, per-requester job fields and the shared PWM status bundle.
// Fields for requester i sit in slice [i*W +: W] of each packed bus.
interface duty_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int BW   = 8,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*CW-1:0] req_period;
    logic [NREQ*CW-1:0] req_high;
    logic [NREQ*BW-1:0] req_bursts;
    logic               pwm_out;
    logic               busy;
    logic [IDW-1:0]     grant_id;
    logic               done_pulse;
    logic [IDW-1:0]     done_id;

    modport slave (
        input  req_valid, req_period, req_high, req_bursts,
        output req_ready, pwm_out, busy, grant_id, done_pulse, done_id
    );

    modport master (
        output req_valid, req_period, req_high, req_bursts,
        input  req_ready, pwm_out, busy, grant_id, done_pulse, done_id
    );
endinterface

// File: rtl/duty_sched.sv
// Round-robin shared PWM scheduler: grant -> (P+1)(B+1) registered PWM cycles -> 1-cycle done strobe.
// Latency: outputs lag the FSM by one register stage; backpressure: req_ready only in IDLE, zero otherwise.
module duty_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int BW   = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic        clk,
    input  logic        reset,
    duty_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] done_id_q, done_id_d;
    logic [CW-1:0]  cnt_q, cnt_d, p_q, p_d, h_q, h_d;
    logic [BW-1:0]  bcnt_q, bcnt_d, b_q, b_d;
    logic           pwm_q, pwm_d, busy_q, busy_d, done_q, done_d;

    logic [2*NREQ-1:0] dbl;
    logic [IDW:0]      off, sum;
    logic [IDW-1:0]    win;
    logic              win_vld, hs;
    logic [NREQ-1:0]   ready;
    logic [CW-1:0]     p_sel, h_sel;
    logic [BW-1:0]     b_sel;

    // Rotate valid so the search starts at ptr; lowest set bit is the winner's offset.
    always_comb begin
        dbl     = {bus.req_valid, bus.req_valid} >> ptr_q;
        win_vld = 1'b0;
        off     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                win_vld = 1'b1;
                off     = (IDW+1)'(j);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
        end
        win = sum[IDW-1:0];
    end

    always_comb begin
        p_sel = '0;
        h_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                p_sel = bus.req_period[i*CW +: CW];
                h_sel = bus.req_high[i*CW +: CW];
                b_sel = bus.req_bursts[i*BW +: BW];
            end
        end
    end

    // Gated by reset so no requester sees a grant while the block is held in reset.
    always_comb begin
        ready = '0;
        hs    = (state_q == IDLE) && reset && win_vld;
        if (hs) begin
            ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        done_id_d = done_id_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        p_d       = p_q;
        h_d       = h_q;
        b_d       = b_q;
        pwm_d     = 1'b0;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    p_d     = p_sel;
                    h_d     = h_sel;
                    b_d     = b_sel;
                    grant_d = win;
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                pwm_d = (cnt_q < h_q);
                if (cnt_q == p_q) begin
                    cnt_d  = '0;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == b_q) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                done_id_d = grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            done_id_q <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            p_q       <= '0;
            h_q       <= '0;
            b_q       <= '0;
            pwm_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_id_q <= done_id_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            p_q       <= p_d;
            h_q       <= h_d;
            b_q       <= b_d;
            pwm_q     <= pwm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.pwm_out    = pwm_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
    assign bus.done_pulse = done_q;
    assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_duty_sched.sv
// Bench for duty_sched: directed scenarios plus randomized jobs against a queue-based PWM/arbitration model.
module tb_duty_sched;
    localparam int NREQ = 4;
    localparam int CW   = 8;
    localparam int BW   = 8;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    duty_sched_if #(.NREQ(NREQ), .CW(CW), .BW(BW)) bus();
    duty_sched #(.NREQ(NREQ), .CW(CW), .BW(BW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;

    logic [NREQ-1:0] cfg_v;
    int cfg_p[NREQ];
    int cfg_h[NREQ];
    int cfg_b[NREQ];

    task automatic apply_cfg();
        bus.req_valid = cfg_v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_period[i*CW +: CW] = CW'(cfg_p[i]);
            bus.req_high[i*CW +: CW]   = CW'(cfg_h[i]);
            bus.req_bursts[i*BW +: BW] = BW'(cfg_b[i]);
        end
    endtask

    task automatic set_req(input int i, input int p, input int h, input int b);
        cfg_p[i] = p;
        cfg_h[i] = h;
        cfg_b[i] = b;
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Entered at a negedge with the DUT in IDLE; returns at the negedge showing done_pulse.
    task automatic serve_one(input bit drop, input bit scramble, output int who);
        int exp_w;
        bit q[$];
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ+2:0] got_run, exp_run;
        logic [IDW+2:0]  got_done, exp_done;
        #1;
        one     = 1;
        exp_w   = model_winner(cfg_v, model_ptr);
        exp_rdy = (exp_w < 0) ? '0 : (one << exp_w);
        n_checks++;
        if (bus.req_ready !== exp_rdy)
            $display("FAIL grant_ready: req_ready=%b expected %b (valid=%b ptr=%0d)", bus.req_ready, exp_rdy, cfg_v, model_ptr);
        else n_pass++;
        who = (exp_w < 0) ? 0 : exp_w;
        model_ptr = (who + 1) % NREQ;
        for (int bb = 0; bb <= cfg_b[who]; bb++)
            for (int c = 0; c <= cfg_p[who]; c++)
                q.push_back(c < cfg_h[who]);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== IDW'(who))
            $display("FAIL grant_cycle: busy=%b grant_id=%0d expected busy=0 grant_id=%0d", bus.busy, bus.grant_id, who);
        else n_pass++;
        if (drop) begin
            cfg_v[who] = 1'b0;
            apply_cfg();
        end
        for (int j = 0; j < q.size(); j++) begin
            if (scramble) begin
                bus.req_valid = NREQ'($urandom);
                for (int i = 0; i < NREQ; i++) begin
                    bus.req_period[i*CW +: CW] = CW'($urandom);
                    bus.req_high[i*CW +: CW]   = CW'($urandom);
                    bus.req_bursts[i*BW +: BW] = BW'($urandom);
                end
            end
            @(negedge clk);
            got_run = {bus.pwm_out, bus.busy, bus.done_pulse, bus.req_ready};
            exp_run = {q[j], 1'b1, 1'b0, {NREQ{1'b0}}};
            n_checks++;
            if (got_run !== exp_run)
                $display("FAIL run_cycle%0d req%0d: {pwm,busy,done,ready}=%b expected %b", j, who, got_run, exp_run);
            else n_pass++;
        end
        @(negedge clk);
        got_done = {bus.done_pulse, bus.done_id, bus.pwm_out, bus.busy};
        exp_done = {1'b1, IDW'(who), 1'b0, 1'b1};
        n_checks++;
        if (got_done !== exp_done)
            $display("FAIL done_cycle req%0d: {done,done_id,pwm,busy}=%b expected %b", who, got_done, exp_done);
        else n_pass++;
        apply_cfg();
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        n_checks++;
        if (bus.done_pulse !== 1'b0 || bus.busy !== 1'b0 || bus.pwm_out !== 1'b0)
            $display("FAIL %s idle: done=%b busy=%b pwm=%b expected 0 0 0", tag, bus.done_pulse, bus.busy, bus.pwm_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2, 1, 0);
        cfg_v = '1;
        apply_cfg();
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b expected 0", bus.req_ready);
        else n_pass++;
        n_checks++;
        if ({bus.pwm_out, bus.busy, bus.done_pulse} !== 3'b000)
            $display("FAIL reset_outputs: pwm/busy/done=%b expected 000", {bus.pwm_out, bus.busy, bus.done_pulse});
        else n_pass++;
        n_checks++;
        if (bus.grant_id !== '0 || bus.done_id !== '0)
            $display("FAIL reset_ids: grant_id=%0d done_id=%0d expected 0 0", bus.grant_id, bus.done_id);
        else n_pass++;
        cfg_v = '0;
        apply_cfg();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single_25();
        int who;
        set_req(0, 3, 1, 2);
        cfg_v = 4'b0001;
        apply_cfg();
        serve_one(1'b1, 1'b0, who);
        check_idle_after("single_25");
    endtask

    task automatic test_extremes();
        int who;
        set_req(1, 4, 0, 0);
        cfg_v = 4'b0010; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        set_req(2, 3, 9, 1);
        cfg_v = 4'b0100; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        set_req(3, 0, 1, 3);
        cfg_v = 4'b1000; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        check_idle_after("extremes");
    endtask

    task automatic test_round_robin();
        int who;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 1, 0);
        cfg_v = '1;
        apply_cfg();
        @(negedge clk);
        reset = 1'b1;
        model_ptr = 0;
        for (int n = 0; n < 6; n++) serve_one(1'b0, 1'b0, who);
        cfg_v = '0;
        apply_cfg();
        check_idle_after("round_robin");
    endtask

    task automatic test_sparse();
        int who;
        set_req(0, 1, 1, 0);
        set_req(1, 2, 2, 0);
        set_req(2, 2, 1, 1);
        set_req(3, 1, 0, 0);
        cfg_v = 4'b0001; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        cfg_v = 4'b0101; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        serve_one(1'b1, 1'b0, who);
        cfg_v = 4'b1111; apply_cfg();
        serve_one(1'b1, 1'b0, who);
        cfg_v = '0; apply_cfg();
        check_idle_after("sparse");
    endtask

    task automatic test_reset_mid_job();
        int who;
        set_req(0, 7, 3, 5);
        cfg_v = 4'b0001; apply_cfg();
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL midrst_grant: ready=%b expected 0001", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        cfg_v = '0; apply_cfg();
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.pwm_out !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL midrst_running: pwm=%b busy=%b expected 1 1", bus.pwm_out, bus.busy);
        else n_pass++;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.pwm_out, bus.busy, bus.done_pulse} !== 3'b000)
            $display("FAIL midrst_async: pwm/busy/done=%b expected 000", {bus.pwm_out, bus.busy, bus.done_pulse});
        else n_pass++;
        cfg_v = '1; apply_cfg();
        #1;
        n_checks++;
        if (bus.req_ready !== '0) $display("FAIL midrst_ready: ready=%b expected 0", bus.req_ready);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done_pulse !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL midrst_hold%0d: done=%b busy=%b expected 0 0", n, bus.done_pulse, bus.busy);
            else n_pass++;
        end
        reset = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 0);
        apply_cfg();
        serve_one(1'b1, 1'b0, who);
        cfg_v = '0; apply_cfg();
        check_idle_after("reset_mid_job");
    endtask

    task automatic test_isolation();
        int who;
        set_req(1, 4, 2, 2);
        cfg_v = 4'b0010; apply_cfg();
        serve_one(1'b1, 1'b1, who);
        check_idle_after("isolation");
    endtask

    task automatic test_random();
        int who;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3));
            cfg_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            apply_cfg();
            serve_one(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), who);
        end
        cfg_v = '0; apply_cfg();
        check_idle_after("random");
    endtask

    initial begin
        cfg_v = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);
        apply_cfg();
        test_reset();
        test_single_25();
        test_extremes();
        test_round_robin();
        test_sparse();
        test_reset_mid_job();
        test_isolation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
